// File: rtl/dm_access_ctrl.sv
// Load/store initiator between the MEM stage and data memory (one request in flight).
// Optional DM_ACCESS_CNT_EN adds ld_cnt/st_cnt counters of successful loads/stores.
module dm_access_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int DM_WORDS_LOG2 = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_invalue,
  output logic              dm_memwrite,
  output logic              dm_memread,
  input  logic [31:0]       dm_outvalue
`ifdef DM_ACCESS_CNT_EN
  ,
  output logic [31:0]       ld_cnt,
  output logic [31:0]       st_cnt
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  logic [2:0]        state_reg, state_next;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              sign_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              size_bad;
  logic              align_bad;
  logic              range_bad;
  logic              accept_err;
  logic [3:0]        lane_en;
  logic [31:0]       merged_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_ext;

  assign accept = req_valid && req_ready;

  // Error classification is done on the live request so the bad case
  // can jump straight to RESP without ever touching dm.
  assign size_bad   = (req_size == SZ_ILL);
  assign align_bad  = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign range_bad  = ((req_addr >> (DM_WORDS_LOG2 + 2)) != '0);
  assign accept_err = size_bad || align_bad || range_bad;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (accept_err)
            state_next = ST_RESP;
          else if (!req_we)
            state_next = ST_LOAD;
          else if (req_size == SZ_WORD)
            state_next = ST_STORE;
          else
            state_next = ST_MERGE;
        end
      end
      ST_LOAD:  state_next = ST_RESP;
      ST_MERGE: state_next = ST_STORE;
      ST_STORE: state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Byte lanes are little-endian: lane k holds word[8k+7:8k].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] wr_lane;

      assign lane_en[gi] = (size_reg == SZ_BYTE) ? (addr_reg[1:0] == LANE)
                                                 : (addr_reg[1] == LANE[1]);
      assign wr_lane     = (size_reg == SZ_HALF && LANE[0]) ? data_reg[15:8]
                                                            : data_reg[7:0];
      assign merged_word[8*gi +: 8] = lane_en[gi] ? wr_lane
                                                  : dm_outvalue[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ld_byte = dm_outvalue[7:0];
    case (addr_reg[1:0])
      2'd0: ld_byte = dm_outvalue[7:0];
      2'd1: ld_byte = dm_outvalue[15:8];
      2'd2: ld_byte = dm_outvalue[23:16];
      2'd3: ld_byte = dm_outvalue[31:24];
      default: ld_byte = dm_outvalue[7:0];
    endcase
  end

  assign ld_half = addr_reg[1] ? dm_outvalue[31:16] : dm_outvalue[15:0];

  always_comb begin
    load_ext = dm_outvalue;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{sign_reg & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_ext = {{16{sign_reg & ld_half[15]}}, ld_half};
      default: load_ext = dm_outvalue;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      size_reg  <= 2'd0;
      sign_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= 32'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        sign_reg  <= req_sign;
        addr_reg  <= req_addr;
        data_reg  <= req_wdata;
        rdata_reg <= 32'd0;
        err_reg   <= accept_err;
      end
      if (state_reg == ST_LOAD)
        rdata_reg <= load_ext;
      // data_reg becomes the full word to write back once the old lanes are in.
      if (state_reg == ST_MERGE)
        data_reg <= merged_word;
    end
  end

  assign req_ready   = (state_reg == ST_IDLE);
  assign dm_memread  = (state_reg == ST_LOAD) || (state_reg == ST_MERGE);
  assign dm_memwrite = (state_reg == ST_STORE);
  assign dm_addr     = {addr_reg[ADDR_W-1:2], 2'b00};
  assign dm_invalue  = data_reg;
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_err     = (state_reg == ST_RESP) && err_reg;
  assign rsp_rdata   = (state_reg == ST_RESP) ? rdata_reg : 32'd0;

`ifdef DM_ACCESS_CNT_EN
  logic [31:0] ld_cnt_reg;
  logic [31:0] st_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt_reg <= 32'd0;
      st_cnt_reg <= 32'd0;
    end else if (state_reg == ST_RESP && !err_reg) begin
      if (we_reg)
        st_cnt_reg <= st_cnt_reg + 32'd1;
      else
        ld_cnt_reg <= ld_cnt_reg + 32'd1;
    end
  end

  assign ld_cnt = ld_cnt_reg;
  assign st_cnt = st_cnt_reg;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: a byte-level memory model predicts every response.
`timescale 1ns/1ps
module tb_dm_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_invalue;
  logic        dm_memwrite;
  logic        dm_memread;
  logic [31:0] dm_outvalue;
`ifdef DM_ACCESS_CNT_EN
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;
`endif

  dm_access_ctrl #(.ADDR_W(32), .DM_WORDS_LOG2(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_sign    (req_sign),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .dm_addr     (dm_addr),
    .dm_invalue  (dm_invalue),
    .dm_memwrite (dm_memwrite),
    .dm_memread  (dm_memread),
    .dm_outvalue (dm_outvalue)
`ifdef DM_ACCESS_CNT_EN
    ,
    .ld_cnt      (ld_cnt),
    .st_cnt      (st_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] dm_mem [1024];
  logic [31:0] ref_mem[1024];
  logic        load_mem;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  int          exp_ld = 0;
  int          exp_st = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write on the rising edge.
  assign dm_outvalue = dm_mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) dm_mem[i] <= ref_mem[i];
    end else if (dm_memwrite) begin
      dm_mem[dm_addr[11:2]] <= dm_invalue;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain byte arithmetic on a word array.
  task automatic model(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int unsigned nb, off, idx;
    logic [31:0] w, mask, val;
    e.rdata = 32'd0; e.err = 1'b0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.acc = 0;
    nb  = (size == 2'd3) ? 0 : (1 << size);
    off = addr % 4;
    idx = (addr / 4) % 1024;
    e.err = (nb == 0) || (addr >= 32'd4096) || ((addr % nb) != 0);
    if (e.err) return;
    w = ref_mem[idx];
    if (!we) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      val  = (w >> (8 * off)) & mask;
      if (sign && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
      e.rdata = val; e.lat = 2; e.nrd = 1;
      exp_ld++;
    end else begin
      for (int i = 0; i < int'(nb); i++) w[8 * (int'(off) + i) +: 8] = wdata[8 * i +: 8];
      ref_mem[idx] = w;
      e.lat = (nb == 4) ? 2 : 3; e.nrd = (nb == 4) ? 0 : 1; e.nwr = 1;
      exp_st++;
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(we, size, sign, addr, wdata, e);
    e.acc = cyc;
    sb.push_back(e);
    $display("txn we=%0b size=%0d sign=%0b addr=%h wdata=%h exp_rdata=%h exp_err=%0b",
             we, size, sign, addr, wdata, e.rdata, e.err);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_dm_memread"}, {31'd0, dm_memread}, 32'd0);
    chk({tag, "_dm_memwrite"}, {31'd0, dm_memwrite}, 32'd0);
    chk({tag, "_dm_addr"}, dm_addr, 32'd0);
    chk({tag, "_dm_invalue"}, dm_invalue, 32'd0);
  endtask

  // Monitor: dm activity per transaction, and response compare on rsp_valid.
  always @(negedge clk) begin
    if (!reset) begin
      rd_seen = 0;
      wr_seen = 0;
    end else begin
      chk("rd_wr_exclusive", {31'd0, dm_memread & dm_memwrite}, 32'd0);
      if (dm_memread) rd_seen++;
      if (dm_memwrite) wr_seen++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, got.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, got.err});
          chk("rsp_latency", 32'(cyc - got.acc + 1), 32'(got.lat));
          chk("dm_reads", 32'(rd_seen), 32'(got.nrd));
          chk("dm_writes", 32'(wr_seen), 32'(got.nwr));
        end
        rd_seen = 0;
        wr_seen = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    int          r;
    reset = 1'b0; load_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    check_idle_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Directed cases.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FFA5);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_5678);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h0FFC, 32'hCAFE_F00D);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD_9876);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    drain();

    // Reset while the MERGE read is in progress: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h0000_005A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("merge_reads", {31'd0, dm_memread}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_reset_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_reset_memwrite", {31'd0, dm_memwrite}, 32'd0);
    exp_ld = 0; exp_st = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_mid_reset");
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

    // Randomised traffic concentrated on a few words so stores and loads alias.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      s = (r < 4) ? 2'd3 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 4) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
      else a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 99) < 75 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
      d = $urandom;
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    for (int i = 0; i < 1024; i++) chk("mem_word", dm_mem[i], ref_mem[i]);
`ifdef DM_ACCESS_CNT_EN
    chk("ld_cnt", ld_cnt, 32'(exp_ld));
    chk("st_cnt", st_cnt, 32'(exp_st));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
